dp_ram_be: RTL and testbench

Parametrised simple dual-port RAM (one write port, one read port, single clock) with per-byte write enables, configurable read latency and a hardware clear sequencer that zero-fills the array on request. It replaces plain dual-port buffers in the feature/weight buffering path. Partial-word updates and buffer flush between layers need no external address sweep.

---
 rtl/dp_ram_pkg.sv | 22 ++
 rtl/dp_ram_clr_fsm.sv | 74 +++++++
 rtl/dp_ram_be.sv | 135 +++++++++++++
 tb/tb_dp_ram_be.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared definitions for dp_ram_be: clear-FSM state encoding, read-latency
// bounds and the byte-merge helper used for write-first forwarding.
package dp_ram_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  localparam int unsigned CLR_ST_W = 2;
  typedef logic [CLR_ST_W-1:0] clr_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Select the new byte where its enable is set, otherwise keep the old one.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dp_ram_clr_fsm.sv
// Zero-fill sequencer for dp_ram_be: walks every word once and reports
// busy/done; supplies the clear write address and enable to the array mux.
module dp_ram_clr_fsm
  import dp_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req_i,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  clr_busy_o,
  output logic                  clr_done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  we_q, busy_q, done_q;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= (state_d == ST_CLEAR);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign clr_we_o   = we_q;
  assign clr_addr_o = cnt_q;
  assign clr_busy_o = busy_q;
  assign clr_done_o = done_q;

endmodule

// File: rtl/dp_ram_be.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read latency and a
// hardware zero-fill sequencer. Define DP_RAM_BYPASS_EN for write-first
// same-address forwarding; otherwise same-cycle collisions read first.
module dp_ram_be
  import dp_ram_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 10,
  parameter  int unsigned DATA_WIDTH = 256,
  parameter  int unsigned DATA_DEPTH = 1024,
  parameter  int unsigned RD_LATENCY = 1,
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int unsigned IDX_W   = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned LAT_EFF = (RD_LATENCY >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  dp_ram_clr_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr_req_i  (clr_req),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done)
  );

  logic wr_inr_c, rd_inr_c, wr_fire_c, rd_fire_c;

  assign wr_inr_c  = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_inr_c  = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_fire_c = wr_en && !clr_busy && wr_inr_c;
  assign rd_fire_c = rd_en && !clr_busy;

  // Array write port: the clear sweep owns it while busy, so no arbitration needed.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr[IDX_W-1:0]] <= '0;
    end else if (wr_fire_c) begin
      for (int b = 0; b < int'(BE_WIDTH); b++) begin
        if (wr_be[b]) begin
          mem_q[wr_addr[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_word_c;

  // Read word selection, with optional forwarding of the colliding write.
  always_comb begin
    rd_word_c = '0;
    if (rd_inr_c) begin
      rd_word_c = mem_q[rd_addr[IDX_W-1:0]];
`ifdef DP_RAM_BYPASS_EN
      if (wr_fire_c && (rd_addr == wr_addr)) begin
        for (int b = 0; b < int'(BE_WIDTH); b++) begin
          rd_word_c[8*b +: 8] = merge_byte(rd_word_c[8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
        end
      end
`endif
    end
  end

  logic                  out_valid_c;
  logic [DATA_WIDTH-1:0] out_data_c;

  generate
    if (LAT_EFF == RD_LAT_MAX) begin : g_lat2
      logic                  s1_valid_q;
      logic [DATA_WIDTH-1:0] s1_data_q;

      // Extra stage; in-flight reads drain even if a clear starts behind them.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= rd_fire_c;
          if (rd_fire_c) begin
            s1_data_q <= rd_word_c;
          end
        end
      end

      assign out_valid_c = s1_valid_q;
      assign out_data_c  = s1_data_q;
    end else begin : g_lat1
      assign out_valid_c = rd_fire_c;
      assign out_data_c  = rd_word_c;
    end
  endgenerate

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Output register holds its value until the next completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= out_valid_c;
      if (out_valid_c) begin
        rd_data_q <= out_data_c;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances (1024 words/latency 1, 1000 words/latency 2)
// share stimulus; a reference model feeds per-instance expectation queues.
`timescale 1ns/1ps
module tb_dp_ram_be;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = DW / 8;
  localparam int DEP_A = 1024;
  localparam int DEP_B = 1000;
  localparam int NVEC  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [BEW-1:0] wr_be = '0;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, clr_busy_a, clr_busy_b, clr_done_a, clr_done_b;

  always #5 clk = ~clk;

  dp_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DEP_A), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a));

  dp_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DEP_B), .RD_LATENCY(2)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b));

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic           we;
    logic [AW-1:0]  wa;
    logic [DW-1:0]  wd;
    logic [BEW-1:0] be;
    logic           re;
    logic [AW-1:0]  ra;
    logic [DW-1:0]  ea;
    logic [DW-1:0]  eb;
  } vec_t;

  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] model [2][1024];
  logic [DW-1:0] saved [2][1024];
  logic [DW-1:0] hold  [2];
  int            cs    [2];
  vec_t          vt    [NVEC];

  int   cyc = 0;
  logic rst_prev = 1'b1;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  function automatic int dep(input int d);
    return (d == 0) ? DEP_A : DEP_B;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic bit exp_busy(input int d);
    return (cyc >= cs[d] + 1) && (cyc <= cs[d] + dep(d) + 1);
  endfunction

  function automatic bit exp_done(input int d);
    return cyc == cs[d] + dep(d) + 1;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int due, input logic [DW-1:0] data);
    exp_t e;
    e.due  = due;
    e.data = data;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Compare one instance's outputs against the scoreboard for this cycle.
  task automatic mon_port(input int d, input logic v, input logic [DW-1:0] data,
                          input logic busy, input logic done);
    string s;
    exp_t  e;
    bit    due;
    s = (d == 0) ? "a" : "b";
    if (rst_prev) begin
      chk({"rst_valid_", s}, DW'(v), '0);
      chk({"rst_data_", s}, data, '0);
      chk({"rst_busy_", s}, DW'(busy), '0);
      chk({"rst_done_", s}, DW'(done), '0);
      hold[d] = '0;
      return;
    end
    if (d == 0) due = (q_a.size() > 0) && (q_a[0].due == cyc);
    else        due = (q_b.size() > 0) && (q_b[0].due == cyc);
    if (due) begin
      if (d == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      chk({"rd_valid_", s}, DW'(v), DW'(1'b1));
      chk({"rd_data_", s}, data, e.data);
      hold[d] = e.data;
    end else begin
      chk({"spurious_valid_", s}, DW'(v), '0);
      chk({"hold_", s}, data, hold[d]);
    end
    if (!rst) begin
      chk({"clr_busy_", s}, DW'(busy), DW'(exp_busy(d)));
      chk({"clr_done_", s}, DW'(done), DW'(exp_done(d)));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_port(0, rd_valid_a, rd_data_a, clr_busy_a, clr_done_a);
      mon_port(1, rd_valid_b, rd_data_b, clr_busy_b, clr_done_b);
    end
  end

  // Reference behaviour of one instance for the access presented this cycle.
  task automatic model_step(input int d, input logic we, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic [BEW-1:0] be,
                            input logic re, input logic [AW-1:0] ra, input logic clr,
                            input bit ovr, input logic [DW-1:0] ex);
    logic [DW-1:0] rv;
    if (exp_busy(d)) return;
    rv = '0;
    if (int'(ra) < dep(d)) begin
      rv = model[d][ra];
`ifdef DP_RAM_BYPASS_EN
      if (we && (wa == ra)) begin
        for (int b = 0; b < int'(BEW); b++) if (be[b]) rv[8*b +: 8] = wd[8*b +: 8];
      end
`endif
    end
    if (re) push(d, cyc + lat(d), ovr ? ex : rv);
    if (we && (int'(wa) < dep(d))) begin
      for (int b = 0; b < int'(BEW); b++) if (be[b]) model[d][wa][8*b +: 8] = wd[8*b +: 8];
    end
    if (clr) begin
      cs[d] = cyc;
      for (int k = 0; k < 1024; k++) model[d][k] = '0;
    end
  endtask

  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [BEW-1:0] be, input logic re, input logic [AW-1:0] ra,
                      input logic clr, input bit ovr, input logic [DW-1:0] ea,
                      input logic [DW-1:0] eb);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clr_req = clr;
    model_step(0, we, wa, wd, be, re, ra, clr, ovr, ea);
    model_step(1, we, wa, wd, be, re, ra, clr, ovr, eb);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rd(input int a);
    step(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0; rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    cs[0] = -100000;
    cs[1] = -100000;
  endtask

  initial begin
    logic [DW-1:0] coll;
    int            c0;
`ifdef DP_RAM_BYPASS_EN
    coll = 32'hAAAA_AA55;
`else
    coll = 32'hAAAA_AAAA;
`endif
    //          we    wa       wd             be       re    ra       exp_a          exp_b
    vt[0]  = '{1'b1, 10'd5,    32'hFFFF_FFFF, 4'hF, 1'b0, 10'd0,    32'h0,         32'h0};
    vt[1]  = '{1'b1, 10'd5,    32'h0000_0000, 4'h1, 1'b0, 10'd0,    32'h0,         32'h0};
    vt[2]  = '{1'b0, 10'd0,    32'h0,         4'h0, 1'b1, 10'd5,    32'hFFFF_FF00, 32'hFFFF_FF00};
    vt[3]  = '{1'b1, 10'd3,    32'hAAAA_AAAA, 4'hF, 1'b0, 10'd0,    32'h0,         32'h0};
    vt[4]  = '{1'b1, 10'd3,    32'h5555_5555, 4'h1, 1'b1, 10'd3,    coll,          coll};
    vt[5]  = '{1'b0, 10'd0,    32'h0,         4'h0, 1'b1, 10'd3,    32'hAAAA_AA55, 32'hAAAA_AA55};
    vt[6]  = '{1'b1, 10'd998,  32'h1111_1111, 4'hF, 1'b0, 10'd0,    32'h0,         32'h0};
    vt[7]  = '{1'b1, 10'd999,  32'h2222_2222, 4'hF, 1'b0, 10'd0,    32'h0,         32'h0};
    vt[8]  = '{1'b1, 10'd1000, 32'h3333_3333, 4'hF, 1'b0, 10'd0,    32'h0,         32'h0};
    vt[9]  = '{1'b0, 10'd0,    32'h0,         4'h0, 1'b1, 10'd998,  32'h1111_1111, 32'h1111_1111};
    vt[10] = '{1'b0, 10'd0,    32'h0,         4'h0, 1'b1, 10'd999,  32'h2222_2222, 32'h2222_2222};
    vt[11] = '{1'b0, 10'd0,    32'h0,         4'h0, 1'b1, 10'd1000, 32'h3333_3333, 32'h0};
    vt[12] = '{1'b1, 10'd10,   32'hCAFE_BABE, 4'h0, 1'b1, 10'd10,   32'h0,         32'h0};
    vt[13] = '{1'b0, 10'd0,    32'h0,         4'h0, 1'b1, 10'd10,   32'h0,         32'h0};
    vt[14] = '{1'b1, 10'd20,   32'h1234_5678, 4'hA, 1'b1, 10'd5,    32'hFFFF_FF00, 32'hFFFF_FF00};
    vt[15] = '{1'b0, 10'd0,    32'h0,         4'h0, 1'b1, 10'd20,   32'h1200_5600, 32'h1200_5600};
    vt[16] = '{1'b1, 10'd1023, 32'hDEAD_BEEF, 4'hF, 1'b1, 10'd0,    32'h0,         32'h0};
    vt[17] = '{1'b0, 10'd0,    32'h0,         4'h0, 1'b1, 10'd1023, 32'hDEAD_BEEF, 32'h0};
    vt[18] = '{1'b1, 10'd0,    32'h1234_5678, 4'hF, 1'b0, 10'd0,    32'h0,         32'h0};
    vt[19] = '{1'b0, 10'd0,    32'h0,         4'h0, 1'b1, 10'd0,    32'h1234_5678, 32'h1234_5678};

    cs[0] = -100000;
    cs[1] = -100000;
    hold[0] = '0;
    hold[1] = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_reset(2);

    // Full clear; accesses and a second request during the sweep must be ignored.
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++)
      step(1'b1, AW'(7 + i), 32'h7777_7777, 4'hF, 1'b1, AW'(7 + i), 1'b1, 1'b0, '0, '0);
    while (cyc <= cs[0] + DEP_A + 2) idle(1);
    for (int i = 0; i < 5; i++) rd(7 + i);
    idle(3);

    for (int i = 0; i < NVEC; i++)
      step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].be, vt[i].re, vt[i].ra, 1'b0, 1'b1,
           vt[i].ea, vt[i].eb);
    idle(10);

    // Reset at counter 100 aborts the sweep and leaves the tail untouched.
    saved = model;
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
    c0 = cs[0];
    while (cyc < c0 + 101) idle(1);
    do_reset(1);
    model = saved;
    for (int d = 0; d < 2; d++) for (int k = 0; k <= 100; k++) model[d][k] = '0;
    rd(0); rd(3); rd(50); rd(99); rd(998); rd(999); rd(1023);
    idle(3);

    // Fill everything, stream across the depth boundary, then clear and sweep reads.
    for (int k = 0; k < 1024; k++)
      step(1'b1, AW'(k), DW'(k) ^ 32'hA5A5_0000, 4'hF, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int k = 990; k < 1010; k++) rd(k);
    idle(3);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
    while (cyc <= cs[0] + DEP_A + 2) idle(1);
    for (int k = 0; k < 1024; k++) rd(k);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
